// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - shared input-stage constants and debounce state encodings
package button_debounce_pkg;

  localparam int STABLE_CYCLES_DEFAULT = 50000;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHK_HI    = 2'b01,
    STABLE_HI = 2'b10,
    CHK_LO    = 2'b11
  } deb_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous single-bit inputs
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - push-button debouncer: out follows in once the synchronized
// level has held for STABLE_CYCLES consecutive clocks
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          s;
  deb_state_t    state;
  logic [CW-1:0] cnt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (s)
  );

  // cnt only ever runs inside CHK_*, and is cleared on every entry and exit,
  // so it tops out at CNT_LAST and never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= STABLE_LO;
      cnt   <= '0;
      out   <= 1'b0;
    end else begin
      case (state)
        STABLE_LO: begin
          if (s) begin
            state <= CHK_HI;
            cnt   <= '0;
          end
        end
        CHK_HI: begin
          if (!s) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HI;
            cnt   <= '0;
            out   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state <= CHK_LO;
            cnt   <= '0;
          end
        end
        CHK_LO: begin
          if (s) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LO;
            cnt   <= '0;
            out   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
          out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - scoreboard bench for button_debounce with a run-length reference model
module tb_button_debounce;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in  = 1'b0;
  logic out;

  always #5 clk = ~clk;

  button_debounce #(.STABLE_CYCLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  bit exp_q[$];
  bit samp[$];
  bit m_out = 1'b0;
  int m_falls = 0;
  int d_falls = 0;
  bit d_prev = 1'b0;

  task automatic check(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cycle, act, expv);
    end
  endtask

  // Reference: in reaches s two edges late; out flips once the last N+1 s values
  // seen by the checker all differ from out. Reset empties the history to 0.
  task automatic model_edge(input bit r, input bit i);
    bit all_diff;
    if (!r) begin
      foreach (samp[k]) samp[k] = 1'b0;
      if (m_out) m_falls++;
      m_out = 1'b0;
    end else begin
      samp.push_back(i);
      void'(samp.pop_front());
      all_diff = 1'b1;
      for (int k = 0; k <= N; k++)
        if (samp[k] == m_out) all_diff = 1'b0;
      if (all_diff) begin
        if (m_out) m_falls++;
        m_out = ~m_out;
      end
    end
  endtask

  task automatic step(input bit r, input bit i);
    @(negedge clk);
    rst = r;
    in  = i;
    @(posedge clk);
    model_edge(r, i);
    exp_q.push_back(m_out);
  endtask

  task automatic hold(input bit r, input bit i, input int n);
    for (int k = 0; k < n; k++) step(r, i);
  endtask

  initial begin : monitor
    bit e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out", out, e);
        if (d_prev && !out) d_falls++;
        d_prev = out;
      end
    end
  end

  initial begin : stimulus
    int lvl;
    int len;
    for (int k = 0; k < N + 3; k++) samp.push_back(1'b0);

    hold(0, 1, 10);                 // reset held with button pressed
    hold(1, 1, 12);                 // release: out rises N+2 edges later
    hold(1, 0, 12);
    hold(1, 1, 20);                 // clean press and release
    hold(1, 0, 12);
    step(1, 1); step(1, 0); step(1, 1); step(1, 0);
    hold(1, 1, 12);                 // bounce then settle high
    hold(1, 0, 12);
    hold(1, 1, 3);                  // short pulse
    hold(1, 0, 10);
    hold(1, 1, 12);
    hold(1, 0, 3);                  // short dip while high
    hold(1, 1, 10);
    hold(1, 0, 12);
    hold(1, 1, 4);                  // drop exactly on the final count edge
    hold(1, 0, 10);
    hold(1, 1, 5);                  // reset mid-count, button still held
    step(0, 1);
    hold(1, 1, 12);

    // asynchronous reset must clear out without a clock edge
    @(negedge clk);
    rst = 1'b0;
    in  = 1'b1;
    #1;
    check("async_reset", out, 1'b0);
    @(posedge clk);
    model_edge(0, 1);
    exp_q.push_back(m_out);
    hold(1, 0, 10);

    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 15) == 0) begin
        hold(0, $urandom_range(0, 1), $urandom_range(1, 2));
      end else begin
        lvl = $urandom_range(0, 1);
        len = $urandom_range(1, 8);
        hold(1, lvl[0], len);
      end
    end
    hold(1, 0, 12);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected samples left unchecked, required 0", exp_q.size());
    end
    checks++;
    if (d_falls != m_falls) begin
      errors++;
      $display("FAIL fall_count: got %0d falling edges expected %0d", d_falls, m_falls);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
- REQ-001: Parameter STABLE_CYCLES, default 50000, SHALL set the number of consecutive clk cycles a synchronized level must hold before out follows it (1 ms at 50 MHz); legal range 2..2^20.
- REQ-002: Port clk, input, 1, SHALL be the single system clock; all state updates on posedge clk.
- REQ-003: Port rst, input, 1, SHALL be the asynchronous active-low reset (0 = reset asserted).
- REQ-004: Port in, input, 1, SHALL be the raw, asynchronous, bouncing push-button level (1 = pressed).
- REQ-005: Port out, output, 1, SHALL be the debounced, synchronous button level, registered, fed directly to the downstream edge detector's in.

Function
- REQ-006: in SHALL pass through a 2-flop synchronizer; its second-stage output s is the only form of in used by later logic.
- REQ-007: The FSM SHALL have four states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
- REQ-008: In STABLE_LO (out=0), s=1 SHALL move to CHK_HI with cnt cleared to 0; otherwise it SHALL hold.
- REQ-009: In CHK_HI, s=0 SHALL return to STABLE_LO with cnt cleared and out unchanged (0).
- REQ-010: In CHK_HI with s=1, cnt SHALL increment; when cnt = STABLE_CYCLES-1 and s=1, the FSM SHALL move to STABLE_HI and out SHALL become 1 on the same edge.
- REQ-011: STABLE_HI/CHK_LO SHALL mirror REQ-008..010 with levels inverted; out falls to 0 on entry to STABLE_LO.
- REQ-012: out SHALL change only on STABLE_* entry, only once per accepted transition, and never glitch while in CHK_* states.
- REQ-013: Latency: a clean in step first sampled at edge k SHALL appear on out at edge k+2+STABLE_CYCLES; a level held fewer than STABLE_CYCLES cycles at s SHALL never reach out.
- REQ-014: cnt width SHALL be clog2(STABLE_CYCLES); cnt SHALL saturate/never wrap, as it is cleared on every CHK_* entry and exit.
- REQ-015: A bounce (s flips) in a CHK_* state on the same edge cnt reaches STABLE_CYCLES-1 SHALL abort the transition (return to originating STABLE_* state).
- REQ-016: Illegal state encodings SHALL recover to STABLE_LO with out=0 on the next edge.

Reset
- REQ-017: rst=0 SHALL immediately (no clk needed) force both synchronizer flops to 0, state to STABLE_LO, cnt to 0, out to 0.
- REQ-018: Reset asserted mid-CHK_HI SHALL discard the partial count; after release, a still-pressed button SHALL require the full 2+STABLE_CYCLES edges again.
- REQ-019: Deassertion of rst is assumed synchronized externally; the block SHALL not add a reset synchronizer.

Structure
- REQ-020: State encodings (2-bit) and the default STABLE_CYCLES value SHALL live in the shared calc_defs constants file used by all input-stage blocks.
- REQ-021: The 2-flop synchronizer SHALL be a separate sub-module sync_2ff (clk, rst, d, q), reused by other input paths.
- REQ-022: Target size 120-200 lines RTL; no combinational path from in to out.

Verification (benches use STABLE_CYCLES=4)
- REQ-023: Reset: hold rst=0 with in=1 for 10 cycles -> out=0 throughout, state STABLE_LO; release -> out=1 exactly 6 edges after first sampling edge.
- REQ-024: Clean press: in 0->1 sampled at edge 10, held -> out=1 at edge 16, stays 1; release at edge 30 -> out=0 at edge 36.
- REQ-025: Bounce: in toggles 1,0,1,0 each cycle then settles 1 -> out stays 0 during bounce, rises 6 edges after the final 0->1.
- REQ-026: Short pulse: in=1 for 3 cycles -> out never leaves 0; likewise a 3-cycle low dip while out=1 -> out stays 1.
- REQ-027: Abort at boundary: in drops on the edge cnt would hit 3 -> FSM returns to STABLE_LO, out=0.
- REQ-028: Mid-count reset: rst=0 pulsed at cnt=2 in CHK_HI, in held 1 -> out rises 6 edges after release, not earlier; downstream negedge_detect sees exactly one falling edge per accepted release.
